ir_frame_tx: RTL and testbench
==============================

// Module: ir_frame_tx
// PURPOSE
// Parametrised IR air-conditioner frame transmitter; generalises the fixed 35+32-bit sender.
// Latches a two-segment command on a start strobe and serialises it LSB-first.
// Frame: leader, segment 0, stop mark, inter-segment gap, optional segment 1, stop mark.
// Pulse-distance coding, carrier-modulated. Sits between the key/command logic and the IR LED driver.
// PARAMETERS
// SEG0_BITS    35     segment-0 length in bits (>=1)
// SEG1_BITS    32     segment-1 length in bits (>=1)
// CNT_W        20     width of the phase-duration counter
// CARRIER_HALF 658    clk cycles per carrier half-period (38 kHz at 50 MHz)
// CARRIER_EN   1      1: ir_out = envelope AND carrier; 0: ir_out = envelope (baseband)
// LEAD_MARK    450000 leader mark length, clk cycles
// LEAD_SPACE   225000 leader space length, clk cycles
// BIT_MARK     28000  mark length before every bit and for each stop mark, clk cycles
// ZERO_SPACE   28000  space after the mark for a 0 bit
// ONE_SPACE    84000  space after the mark for a 1 bit
// GAP_SPACE    1000000 space between segment-0 stop mark and segment 1
// PORTS
// clk        in  1          system clock
// rst        in  1          asynchronous, active-low reset
// start      in  1          one-cycle request; sampled only when busy=0
// seg1_en    in  1          1: send segment 1; 0: frame ends after segment-0 stop mark
// seg0_data  in  SEG0_BITS  segment-0 payload, bit 0 sent first
// seg1_data  in  SEG1_BITS  segment-1 payload, bit 0 sent first
// ir_out     out 1          modulated IR drive
// env_out    out 1          unmodulated envelope (1 = mark)
// busy       out 1          high from the cycle after start until the frame ends
// done       out 1          one-cycle pulse in the cycle after the last stop mark
// led_out    out 1          activity indicator; equals busy
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; ir_out, env_out, busy, done, led_out = 0.
//   Counters, shift registers and the carrier phase clear. Reset mid-frame aborts immediately; no done.
// - States: IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP0_M, GAP_S, STOP1_M, FIN.
// - IDLE, start=1: latch seg0_data, seg1_data and seg1_en. Enter LEAD_M next edge.
//   busy, env_out = 1 from that cycle (latency 1).
// - Phase duration: each state lasts exactly its parameter count of clk cycles.
//   The down-counter reloads on entry; the state changes when the count reaches 1.
// - Transitions:
//   - LEAD_M -> LEAD_S -> BIT_M(seg0, bit 0).
//   - BIT_M -> BIT_S: space length = ONE_SPACE if the current bit is 1, else ZERO_SPACE.
//   - BIT_S -> BIT_M with the next bit, or, after the last bit of the segment:
//     seg0 -> STOP0_M; seg1 -> STOP1_M.
//   - STOP0_M -> GAP_S if seg1_en latched = 1, else FIN.
//   - GAP_S -> BIT_M(seg1, bit 0).
//   - STOP1_M -> FIN.
//   - FIN (1 cycle): done=1, busy=0, then IDLE.
// - Bit index counter covers 0..max(SEG0_BITS,SEG1_BITS)-1. It resets to 0 at the start of each segment.
// - env_out = 1 in LEAD_M, BIT_M, STOP0_M, STOP1_M; 0 elsewhere.
// - Carrier:
//   - The carrier counter restarts on every mark entry, so each mark begins with carrier high.
//   - The carrier toggles every CARRIER_HALF cycles. It is held low during spaces.
//   - A mark of odd length may end mid-half-period; the carrier is truncated, not extended.
// - start while busy=1 (including the FIN cycle) is ignored; no queueing.
//   start arriving in the same cycle that IDLE is re-entered is accepted.
// - Input data changes after latch do not affect the frame in flight.
// - Frame length in cycles:
//   T = LEAD_MARK + LEAD_SPACE + sum over seg0 bits(BIT_MARK + space) + BIT_MARK
//     + seg1_en * (GAP_SPACE + sum over seg1 bits(BIT_MARK + space) + BIT_MARK).
// TESTING
// Bench parameters: CARRIER_HALF=2, LEAD_MARK=16, LEAD_SPACE=8, BIT_MARK=4, ZERO_SPACE=4,
//   ONE_SPACE=12, GAP_SPACE=20, SEG0_BITS=35, SEG1_BITS=32.
// 1. Reset low for 3 cycles, then release.
//    -> All outputs 0; no activity for 50 cycles without start.
// 2. seg0=0, seg1=0, seg1_en=1, start pulse.
//    -> busy high for exactly 588 cycles; done pulses once on cycle 589; ir_out toggles every 2 cycles inside marks.
// 3. seg0=35'h7FFFFFFFF, seg1_en=0.
//    -> busy = 16+8+35*16+4 = 588 cycles; every bit space is 12 cycles; no GAP_S visited.
// 4. seg0=35'b1111100000111110000011111000001111, seg1=32'hF83E0F83, seg1_en=1.
//    -> Decode env_out spaces (4 = 0, 12 = 1); the recovered bits match the inputs LSB-first.
// 5. start re-pulsed mid-frame and seg0_data changed mid-frame.
//    -> Frame is unchanged and ends at the same cycle as scenario 2; no second frame starts.
// 6. rst asserted during BIT_S of seg1.
//    -> All outputs 0 in the same cycle, no done. A start after release sends a full fresh frame.
// CARRIER_EN=0 rerun of scenario 2 -> ir_out == env_out on every cycle.

Source files
------------

// File: rtl/ir_frame_tx_if.sv
// Command/status bundle between the key logic and the IR frame transmitter.
// master drives the command side; slave (the transmitter) drives the IR/status side.
interface ir_frame_tx_if #(
  parameter int SEG0_BITS = 35,
  parameter int SEG1_BITS = 32
);
  logic                 start;
  logic                 seg1_en;
  logic [SEG0_BITS-1:0] seg0_data;
  logic [SEG1_BITS-1:0] seg1_data;
  logic                 ir_out;
  logic                 env_out;
  logic                 busy;
  logic                 done;
  logic                 led_out;

  modport master (
    output start, seg1_en, seg0_data, seg1_data,
    input  ir_out, env_out, busy, done, led_out
  );

  modport slave (
    input  start, seg1_en, seg0_data, seg1_data,
    output ir_out, env_out, busy, done, led_out
  );
endinterface

// File: rtl/ir_frame_tx.sv
// Pulse-distance IR frame transmitter: leader, seg0, stop, optional gap + seg1, stop.
// Frame starts 1 cycle after an accepted start; start is ignored while busy or in FIN.
module ir_frame_tx #(
  parameter int SEG0_BITS    = 35,
  parameter int SEG1_BITS    = 32,
  parameter int CNT_W        = 20,
  parameter int CARRIER_HALF = 658,
  parameter bit CARRIER_EN   = 1'b1,
  parameter int LEAD_MARK    = 450000,
  parameter int LEAD_SPACE   = 225000,
  parameter int BIT_MARK     = 28000,
  parameter int ZERO_SPACE   = 28000,
  parameter int ONE_SPACE    = 84000,
  parameter int GAP_SPACE    = 1000000
) (
  input  logic clk,
  input  logic rst,
  ir_frame_tx_if.slave bus
);

  localparam int MAXB  = (SEG0_BITS > SEG1_BITS) ? SEG0_BITS : SEG1_BITS;
  localparam int IDX_W = $clog2(MAXB + 1);
  localparam logic [IDX_W-1:0] LAST0 = IDX_W'(SEG0_BITS - 1);
  localparam logic [IDX_W-1:0] LAST1 = IDX_W'(SEG1_BITS - 1);
  localparam logic CAR_BYPASS = (CARRIER_EN == 1'b0);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEAD_M  = 4'd1;
  localparam logic [3:0] S_LEAD_S  = 4'd2;
  localparam logic [3:0] S_BIT_M   = 4'd3;
  localparam logic [3:0] S_BIT_S   = 4'd4;
  localparam logic [3:0] S_STOP0_M = 4'd5;
  localparam logic [3:0] S_GAP_S   = 4'd6;
  localparam logic [3:0] S_STOP1_M = 4'd7;
  localparam logic [3:0] S_FIN     = 4'd8;

  logic [3:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_car_cnt;
  logic                 r_car;
  logic [IDX_W-1:0]     r_bit;
  logic                 r_seg;
  logic                 r_en1;
  logic [SEG0_BITS-1:0] r_sh0;
  logic [SEG1_BITS-1:0] r_sh1;

  logic [3:0]       w_nxt;
  logic [CNT_W-1:0] w_dur;
  logic             w_tick;
  logic             w_last;
  logic             w_cur_bit;
  logic             w_enter;
  logic             w_nxt_mark;
  logic             w_env;

  assign w_tick    = (r_cnt == CNT_W'(1));
  assign w_last    = (r_bit == (r_seg ? LAST1 : LAST0));
  assign w_cur_bit = r_seg ? r_sh1[0] : r_sh0[0];
  assign w_enter   = (w_nxt != r_state);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_nxt = S_LEAD_M;
      S_LEAD_M:  if (w_tick) w_nxt = S_LEAD_S;
      S_LEAD_S:  if (w_tick) w_nxt = S_BIT_M;
      S_BIT_M:   if (w_tick) w_nxt = S_BIT_S;
      S_BIT_S: begin
        if (w_tick) begin
          if (w_last) w_nxt = r_seg ? S_STOP1_M : S_STOP0_M;
          else        w_nxt = S_BIT_M;
        end
      end
      S_STOP0_M: if (w_tick) w_nxt = r_en1 ? S_GAP_S : S_FIN;
      S_GAP_S:   if (w_tick) w_nxt = S_BIT_M;
      S_STOP1_M: if (w_tick) w_nxt = S_FIN;
      S_FIN:     w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Entering BIT_S picks its length from the bit whose mark just ended.
  always_comb begin
    w_dur = '0;
    case (w_nxt)
      S_LEAD_M:  w_dur = CNT_W'(LEAD_MARK);
      S_LEAD_S:  w_dur = CNT_W'(LEAD_SPACE);
      S_BIT_M:   w_dur = CNT_W'(BIT_MARK);
      S_BIT_S:   w_dur = w_cur_bit ? CNT_W'(ONE_SPACE) : CNT_W'(ZERO_SPACE);
      S_STOP0_M: w_dur = CNT_W'(BIT_MARK);
      S_GAP_S:   w_dur = CNT_W'(GAP_SPACE);
      S_STOP1_M: w_dur = CNT_W'(BIT_MARK);
      default:   w_dur = '0;
    endcase
  end

  assign w_nxt_mark = (w_nxt == S_LEAD_M) || (w_nxt == S_BIT_M) ||
                      (w_nxt == S_STOP0_M) || (w_nxt == S_STOP1_M);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_car_cnt <= '0;
      r_car     <= 1'b0;
      r_bit     <= '0;
      r_seg     <= 1'b0;
      r_en1     <= 1'b0;
      r_sh0     <= '0;
      r_sh1     <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_enter)             r_cnt <= w_dur;
      else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sh0 <= bus.seg0_data;
            r_sh1 <= bus.seg1_data;
            r_en1 <= bus.seg1_en;
            r_seg <= 1'b0;
            r_bit <= '0;
          end
        end
        S_BIT_S: begin
          if (w_tick) begin
            if (w_last) begin
              r_bit <= '0;
            end else begin
              r_bit <= r_bit + IDX_W'(1);
              if (r_seg) r_sh1 <= r_sh1 >> 1;
              else       r_sh0 <= r_sh0 >> 1;
            end
          end
        end
        S_GAP_S: if (w_tick) r_seg <= 1'b1;
        default: ;
      endcase

      // Carrier phase restarts high on each mark entry; truncated when the mark ends.
      if (w_nxt_mark) begin
        if (w_enter) begin
          r_car     <= 1'b1;
          r_car_cnt <= CNT_W'(CARRIER_HALF);
        end else if (r_car_cnt == CNT_W'(1)) begin
          r_car     <= ~r_car;
          r_car_cnt <= CNT_W'(CARRIER_HALF);
        end else begin
          r_car_cnt <= r_car_cnt - CNT_W'(1);
        end
      end else begin
        r_car     <= 1'b0;
        r_car_cnt <= '0;
      end
    end
  end

  assign w_env = (r_state == S_LEAD_M) || (r_state == S_BIT_M) ||
                 (r_state == S_STOP0_M) || (r_state == S_STOP1_M);

  assign bus.env_out = w_env;
  assign bus.ir_out  = w_env & (r_car | CAR_BYPASS);
  assign bus.busy    = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.done    = (r_state == S_FIN);
  assign bus.led_out = bus.busy;

endmodule

// File: tb/tb_ir_frame_tx.sv
// Bench for ir_frame_tx: table-driven frames checked by a monitor that decodes env_out/ir_out
// against a scoreboard of sent commands, plus mid-frame start, FIN-cycle start and reset cases.
module tb_ir_frame_tx;

  logic clk;
  logic rst;

  ir_frame_tx_if #(.SEG0_BITS(35), .SEG1_BITS(32)) m  ();
  ir_frame_tx_if #(.SEG0_BITS(35), .SEG1_BITS(32)) m2 ();

  assign m2.start     = m.start;
  assign m2.seg1_en   = m.seg1_en;
  assign m2.seg0_data = m.seg0_data;
  assign m2.seg1_data = m.seg1_data;

  ir_frame_tx #(
    .SEG0_BITS(35), .SEG1_BITS(32), .CNT_W(20), .CARRIER_HALF(2), .CARRIER_EN(1'b1),
    .LEAD_MARK(16), .LEAD_SPACE(8), .BIT_MARK(4), .ZERO_SPACE(4), .ONE_SPACE(12),
    .GAP_SPACE(20)
  ) dut (.clk(clk), .rst(rst), .bus(m));

  ir_frame_tx #(
    .SEG0_BITS(35), .SEG1_BITS(32), .CNT_W(20), .CARRIER_HALF(2), .CARRIER_EN(1'b0),
    .LEAD_MARK(16), .LEAD_SPACE(8), .BIT_MARK(4), .ZERO_SPACE(4), .ONE_SPACE(12),
    .GAP_SPACE(20)
  ) dut_bb (.clk(clk), .rst(rst), .bus(m2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] s0;
    logic [31:0] s1;
    logic        en;
    int          len;
  } vec_t;

  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard consumer ----------------
  int           in_frame = 0, len = 0, run = 0, pos = 0, nb = 0, car_err = 0;
  int           done_seen = 0, aborted = 0, ir2_err = 0, led_err = 0;
  logic         envp = 1'b0, prev_busy = 1'b0;
  logic [127:0] dec = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_frame != 0) begin
        in_frame = 0;
        if (sb.size() > 0) void'(sb.pop_front());
        aborted++;
      end
      prev_busy = 1'b0;
    end else begin
      if (m2.ir_out !== m2.env_out) ir2_err++;
      if (m.led_out !== m.busy) led_err++;
      if (m.busy) begin
        if (in_frame == 0) begin
          in_frame = 1; len = 0; run = 0; pos = 0; nb = 0; car_err = 0;
          dec = '0; envp = 1'b0;
        end
        len++;
        if (m.env_out) begin
          if (!envp) begin
            if (run == 4 || run == 12) begin
              if (nb < 128) dec[nb] = (run == 12);
              nb++;
            end
            run = 0;
            pos = 0;
          end else begin
            pos++;
          end
          if (m.ir_out !== (((pos / 2) % 2) == 0)) car_err++;
        end else begin
          run++;
          if (m.ir_out !== 1'b0) car_err++;
        end
        envp = m.env_out;
      end
      if (m.done) begin
        vec_t e;
        done_seen++;
        chk("done_after_busy", {127'b0, prev_busy}, 128'd1);
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 128'd0, 128'd1);
        end else begin
          e = sb.pop_front();
          chk("busy_len", 128'(len), 128'(e.len));
          chk("bit_count", 128'(nb), e.en ? 128'd67 : 128'd35);
          chk("bits", dec, {61'b0, (e.en ? e.s1 : 32'b0), e.s0});
          chk("carrier", 128'(car_err), 128'd0);
        end
        in_frame = 0;
      end
      prev_busy = m.busy;
    end
  end

  // ---------------- stimulus ----------------
  int sent = 0;

  task automatic send(input vec_t v);
    @(posedge clk);
    #1;
    m.seg0_data = v.s0;
    m.seg1_data = v.s1;
    m.seg1_en   = v.en;
    m.start     = 1'b1;
    sb.push_back(v);
    sent++;
    @(posedge clk);
    #1;
    m.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 128'd0, 128'd1);
  endtask

  vec_t tbl[4];
  int   act;

  initial begin
    tbl[0] = '{35'h0,          32'h0,          1'b1, 588};
    tbl[1] = '{35'h7FFFFFFFF,  32'h0,          1'b0, 588};
    tbl[2] = '{35'b1111100000111110000011111000001111, 32'hF83E0F83, 1'b1, 876};
    tbl[3] = '{35'h1,          32'h80000000,   1'b0, 316};

    rst = 1'b0;
    m.start = 1'b0;
    m.seg1_en = 1'b0;
    m.seg0_data = '0;
    m.seg1_data = '0;

    // Reset and quiet idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {123'b0, m.ir_out, m.env_out, m.busy, m.done, m.led_out}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    act = 0;
    repeat (50) begin
      @(negedge clk);
      if (m.ir_out | m.env_out | m.busy | m.done | m.led_out) act++;
    end
    chk("idle_quiet", 128'(act), 128'd0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      send(tbl[i]);
      wait_done(1200);
    end

    // Mid-frame start and data change, then start during FIN
    send(tbl[0]);
    repeat (100) @(posedge clk);
    #1;
    m.seg0_data = 35'h5A5A5A5A5;
    m.seg1_data = 32'hFFFFFFFF;
    m.seg1_en   = 1'b0;
    m.start     = 1'b1;
    @(posedge clk);
    #1 m.start = 1'b0;
    wait_done(1200);
    m.start = 1'b1;
    @(posedge clk);
    #1 m.start = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (m.busy) act++;
    end
    chk("no_second_frame", 128'(act), 128'd0);

    // Reset during seg1 BIT_S, then a fresh frame
    send(tbl[0]);
    repeat (334) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {118'b0, m.ir_out, m.env_out, m.busy, m.done, m.led_out,
         m2.ir_out, m2.env_out, m2.busy, m2.done, m2.led_out}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(tbl[2]);
    wait_done(1200);
    repeat (5) @(negedge clk);

    chk("done_count", 128'(done_seen), 128'(sent - 1));
    chk("aborted_frames", 128'(aborted), 128'd1);
    chk("baseband_ir_eq_env", 128'(ir2_err), 128'd0);
    chk("led_eq_busy", 128'(led_err), 128'd0);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
